// File: rtl/gray_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gray_sweep_ctrl
//
// Sweeps a binary counter from a start value to an end value, up or down,
// modulo 2^WIDTH. Each value is offered on a valid/ready output together with
// its Gray code. When the sweep ends or is aborted, the block spends one FIN
// cycle pulsing done and then returns to IDLE.
//
// Optional feature (macro GRAY_SWEEP_CHECK_EN):
//   When defined, every transferred Gray value is compared with the previous
//   transferred value of the same sweep. err is set and stays set until reset
//   if the two differ in anything other than exactly one bit. When undefined,
//   err is tied low and no check logic is built.
//
// Parameters:
//   WIDTH      code width in bits (default 4)
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   start      sweep request, sampled only in IDLE
//   first      sweep start value (binary), latched on an accepted start
//   last       sweep end value (binary), latched on an accepted start
//   dir        0 = count up, 1 = count down, latched on an accepted start
//   abort      ends an active sweep without a further transfer
//   out_ready  consumer ready
//   out_valid  out_bin / out_gray hold a value on offer
//   out_bin    current binary value (registered)
//   out_gray   Gray code of out_bin (zero latency relative to out_bin)
//   busy       high in RUN and FIN
//   done       one-cycle pulse in FIN
//   err        sticky Gray-adjacency error flag
// -----------------------------------------------------------------------------
module gray_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             dir,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_last;
  logic             r_dir;

  logic             w_start_acc;
  logic             w_xfer;
  logic             w_at_last;
  logic [WIDTH-1:0] w_cur_step;

  // Binary to Gray: each Gray bit is the XOR of a binary bit and its upper
  // neighbour.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A start is only seen in IDLE; start during RUN/FIN has no effect.
  assign w_start_acc = (r_state == S_IDLE) && start;

  // Abort wins over a simultaneous handshake, so a cycle with abort high is
  // never a transfer.
  assign w_xfer      = (r_state == S_RUN) && out_ready && !abort;

  assign w_at_last   = (r_cur == r_last);

  // Natural WIDTH-bit wrap gives the modulo 2^WIDTH behaviour in both
  // directions.
  assign w_cur_step  = r_dir ? (r_cur - ONE) : (r_cur + ONE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_FIN;
        end else if (out_ready && w_at_last) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        // Exactly one cycle; a start seen here is dropped.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (Moore, decoded from the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        out_valid = 1'b0;
      end
      S_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      S_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep registers: current value and latched sweep parameters
  // ---------------------------------------------------------------------------
  // r_cur is left alone outside transfers, which holds out_bin during
  // back-pressure, in FIN and in IDLE. On the final transfer it is not stepped,
  // so the last value stays visible after the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_last <= '0;
      r_dir  <= 1'b0;
    end else if (w_start_acc) begin
      r_cur  <= first;
      r_last <= last;
      r_dir  <= dir;
    end else if (w_xfer && !w_at_last) begin
      r_cur  <= w_cur_step;
    end
  end

  assign out_bin  = r_cur;
  assign out_gray = bin2gray(r_cur);

`ifdef GRAY_SWEEP_CHECK_EN
  // ---------------------------------------------------------------------------
  // Gray adjacency check on transferred values
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;
  logic             r_err;

  // True when a and b differ in exactly one bit position.
  function automatic logic one_bit_diff(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - ONE)) == '0);
  endfunction

  // r_have_prev is cleared on every accepted start so the first value of a
  // sweep is never compared against the tail of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_start_acc) begin
      r_have_prev <= 1'b0;
    end else if (w_xfer) begin
      r_prev_gray <= out_gray;
      r_have_prev <= 1'b1;
      if (r_have_prev && !one_bit_diff(r_prev_gray, out_gray)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
module tb_gray_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] first;
  logic [3:0] last;
  logic       dir;
  logic       abort;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_bin;
  logic [3:0] out_gray;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec;
  int n_mis;

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    logic       d;
    int         stall_idx;
    int         stall_cyc;
    int         abort_idx;
    bit         rnd_ready;
    int         exp_n;
  } vec_t;

  gray_sweep_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first     (first),
    .last      (last),
    .dir       (dir),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the k-th value of a sweep, its Gray code and length.
  function automatic logic [3:0] model_val(input logic [3:0] f, input logic d, input int k);
    int v;
    v = d ? (int'(f) - k) : (int'(f) + k);
    v = ((v % 16) + 16) % 16;
    return 4'(v);
  endfunction

  function automatic logic [3:0] model_gray(input logic [3:0] b);
    int v;
    v = int'(b);
    return 4'(v ^ (v / 2));
  endfunction

  function automatic int sweep_len(input logic [3:0] f, input logic [3:0] l, input logic d);
    int diff;
    diff = d ? (int'(f) - int'(l)) : (int'(l) - int'(f));
    return (((diff % 16) + 16) % 16) + 1;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_sweep(input string tag, input vec_t v);
    int         idx;
    int         nx;
    int         stall;
    logic [3:0] ev;
    logic [3:0] hold;
    bit         ab;
    bit         fin_seen;
    bit         ready_b;
    start     = 1'b1;
    first     = v.f;
    last      = v.l;
    dir       = v.d;
    abort     = 1'b0;
    out_ready = 1'($urandom);
    @(negedge clk);
    start    = 1'b0;
    idx      = 0;
    nx       = 0;
    stall    = 0;
    fin_seen = 1'b0;
    hold     = v.f;
    for (int cyc = 0; cyc < 400 && !fin_seen; cyc++) begin
      if (out_valid) begin
        ev = model_val(v.f, v.d, idx);
        check({tag, " bin"},  int'(out_bin),  int'(ev));
        check({tag, " gray"}, int'(out_gray), int'(model_gray(ev)));
        check({tag, " busy_run"}, int'(busy), 1);
        check({tag, " done_run"}, int'(done), 0);
        if (idx == v.stall_idx && stall < v.stall_cyc) begin
          ready_b = 1'b0;
          stall++;
        end else begin
          ready_b = v.rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        ab        = (idx == v.abort_idx);
        out_ready = ready_b;
        abort     = ab;
        hold      = ev;
        if (ready_b && !ab) begin
          nx++;
          idx++;
        end
        // Inputs that must be ignored while a sweep is active.
        start = 1'($urandom);
        first = 4'($urandom);
        last  = 4'($urandom);
        dir   = 1'($urandom);
      end else begin
        fin_seen = 1'b1;
        check({tag, " done_fin"}, int'(done), 1);
        check({tag, " busy_fin"}, int'(busy), 1);
        check({tag, " bin_fin"},  int'(out_bin), int'(hold));
        start     = 1'b0;
        abort     = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
    end
    if (!fin_seen) begin
      check({tag, " sweep_ended"}, 0, 1);
    end
    abort = 1'b0;
    check({tag, " valid_idle"}, int'(out_valid), 0);
    check({tag, " busy_idle"},  int'(busy), 0);
    check({tag, " done_idle"},  int'(done), 0);
    check({tag, " bin_idle"},   int'(out_bin), int'(hold));
    check({tag, " gray_idle"},  int'(out_gray), int'(model_gray(hold)));
    check({tag, " transfers"},  nx, v.exp_n);
    check({tag, " err"},        int'(err), 0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;
    n_vec = 0;
    n_mis = 0;

    //          f      l      d     stall_idx stall_cyc abort_idx rnd  exp_n
    tbl[0] = '{4'd0,  4'd15, 1'b0, -1,       0,        -1,       1'b0, 16};
    tbl[1] = '{4'd14, 4'd1,  1'b0, -1,       0,        -1,       1'b0, 4};
    tbl[2] = '{4'd3,  4'd3,  1'b1, -1,       0,        -1,       1'b0, 1};
    tbl[3] = '{4'd5,  4'd8,  1'b0, 1,        3,        -1,       1'b0, 4};
    tbl[4] = '{4'd0,  4'd15, 1'b0, -1,       0,        2,        1'b0, 2};
    tbl[5] = '{4'd15, 4'd0,  1'b0, -1,       0,        -1,       1'b1, 2};
    tbl[6] = '{4'd0,  4'd15, 1'b1, -1,       0,        -1,       1'b1, 2};
    tbl[7] = '{4'd2,  4'd9,  1'b1, -1,       0,        0,        1'b1, 0};

    rst_n     = 1'b0;
    start     = 1'b0;
    first     = 4'd0;
    last      = 4'd0;
    dir       = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst valid", int'(out_valid), 0);
    check("rst bin",   int'(out_bin),   0);
    check("rst gray",  int'(out_gray),  0);
    check("rst busy",  int'(busy),      0);
    check("rst done",  int'(done),      0);
    check("rst err",   int'(err),       0);
    rst_n = 1'b1;
    @(negedge clk);

    // abort in IDLE does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle abort valid", int'(out_valid), 0);
    check("idle abort busy",  int'(busy),      0);

    for (int i = 0; i < 8; i++) begin
      run_sweep($sformatf("tbl%0d", i), tbl[i]);
    end

    // Explicit Gray endpoints of the 0..15 and 14..1 sweeps.
    run_sweep("full_up", tbl[0]);
    check("full_up last gray", int'(out_gray), 8);
    run_sweep("wrap_up", tbl[1]);
    check("wrap_up last gray", int'(out_gray), 1);

    // Reset in the middle of a sweep: immediate zero outputs, no done.
    start     = 1'b1;
    first     = 4'd0;
    last      = 4'd15;
    dir       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid valid_before", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst valid", int'(out_valid), 0);
    check("mid rst bin",   int'(out_bin),   0);
    check("mid rst gray",  int'(out_gray),  0);
    check("mid rst busy",  int'(busy),      0);
    check("mid rst done",  int'(done),      0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid rst no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst valid", int'(out_valid), 0);
    check("post rst done",  int'(done),      0);
    check("post rst busy",  int'(busy),      0);
    run_sweep("post_rst", tbl[3]);

    // Randomized sweeps against the reference model.
    for (int i = 0; i < 30; i++) begin
      rv.f         = 4'($urandom);
      rv.l         = 4'($urandom);
      rv.d         = 1'($urandom);
      rv.stall_idx = -1;
      rv.stall_cyc = 0;
      rv.rnd_ready = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        rv.abort_idx = $urandom_range(0, sweep_len(rv.f, rv.l, rv.d) - 1);
        rv.exp_n     = rv.abort_idx;
      end else begin
        rv.abort_idx = -1;
        rv.exp_n     = sweep_len(rv.f, rv.l, rv.d);
      end
      run_sweep($sformatf("rnd%0d", i), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
